freq_meter_bcd: RTL and testbench
=================================

Name: freq_meter_bcd

Overview:
- Parametrised successor to the team's fixed 4-digit frequency counter.
- Counts rising edges of an asynchronous input over a fixed gate window derived from the system clock.
- Converts each gate's count to BCD with a sequential double-dabble engine, reporting DIGITS decimal digits, a valid strobe and an overflow flag.
- Feeds the 7-segment display drivers.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- GATE_MS, 1000, gate window length in ms. GATE_CYCLES = (CLK_HZ/1000)*GATE_MS.
- DIGITS, 4, number of BCD digits output (1..9).
- CNT_W, 32, edge-counter and snapshot width.
- SYNC_STAGES, 2, synchroniser flops ahead of the edge detector (>=2).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- signal  in  1  measured input, asynchronous to clk.
- digits  out  4*DIGITS  BCD result; digit 0 (units) in bits [3:0], most significant digit in the top nibble.
- valid  out  1  one-cycle pulse when digits/overflow update.
- overflow  out  1  last completed gate count was >= 10**DIGITS.
- busy  out  1  conversion in progress.

Behaviour:
- Reset (async, active-high):
  - digits=0, valid=0, overflow=0, busy=0.
  - Gate counter=0, edge counter=0, sync chain=0, state IDLE.
  - Reset mid-conversion aborts it: no valid pulse, digits stay 0.
- Input synchronisation and edge detection:
  - signal passes SYNC_STAGES flops, then one history flop.
  - rise = sync_out & ~history.
  - Sync chain resets to 0, so signal already high at reset release counts as one edge.
- Gate counter:
  - Free-runs 0..GATE_CYCLES-1, independent of signal activity. The gate closes even with no edges.
  - Gate end is the cycle where the counter equals GATE_CYCLES-1; the counter wraps to 0 on the next edge.
- Edge counter:
  - Increments on rise and saturates at 2**CNT_W-1.
  - At gate end: snapshot <= edge count + rise (a rise in the gate-end cycle belongs to the closing window), and the edge counter clears to 0.
  - No dead time between windows.
- Conversion FSM: IDLE -> SHIFT -> DONE -> IDLE.
  - IDLE -> SHIFT at gate end: load snapshot and ovf_cmp = (snapshot >= 10**DIGITS), clear internal BCD accumulator, iteration count = CNT_W.
  - SHIFT, one bit per cycle for CNT_W cycles: add 3 to every BCD nibble >= 5, then shift left 1, bringing in the snapshot MSB first. The accumulator is wide enough for 2**CNT_W-1 with no truncation.
  - DONE, one cycle:
    - overflow <= ovf_cmp.
    - digits <= low DIGITS nibbles of the accumulator, or all nibbles 9 if ovf_cmp.
    - valid=1.
  - busy=1 in SHIFT and DONE.
- Latency: gate-end edge T. New digits, overflow and valid are visible after edge T+CNT_W+1; valid is high for exactly that one cycle.
- Outputs hold their value between valid pulses.
- Elaboration check: GATE_CYCLES must be > CNT_W+2, so a conversion always finishes before the next gate end. Violation is a $error at elaboration.
- A gate end can never coincide with a busy state under legal parameters.

Optional Feature:
- Macro: FREQ_METER_BLANK_EN.
- Defined: leading-zero blanking. In DONE, every digit nibble above the most significant non-zero digit is driven 4'hF, which the display driver treats as blank. Digit 0 is never blanked, so a result of 0 shows as a single 0. Overflow output is unaffected, and blanking is not applied when overflow=1 (all nines).
- Undefined: leading zeros are output as 4'h0.

Test Plan (CLK_HZ=100000, GATE_MS=1 -> GATE_CYCLES=100, CNT_W=16, DIGITS=4 unless noted):
1. signal toggles every 5 clk (10 rises/gate) -> after each gate: digits=16'h0010, overflow=0, valid exactly 17 cycles after gate end, one pulse per 100 cycles.
2. Single rise aligned to the gate-end cycle -> counted in the closing window (digits=16'h0001); the following window reports 0 if no further edges.
3. signal toggles every clk with DIGITS=1 (50 rises) -> overflow=1, digits=4'h9. Same stimulus with DIGITS=2 -> digits=8'h50, overflow=0.
4. Assert rst during SHIFT, release 3 cycles later with 10 rises/gate stimulus -> no valid during abort, digits=0; the next full gate reports 16'h0010.
5. signal held low -> valid still pulses every gate, digits=16'h0000. Hold high from reset release -> first gate reports 1, later gates 0.
6. FREQ_METER_BLANK_EN defined, 10 rises/gate -> digits=16'hFF10. 0 rises -> 16'hFFF0.

Source files
------------

// File: rtl/freq_meter_bcd.sv
// Gated frequency meter: counts rising edges of an asynchronous input per gate window
// and converts each count to DIGITS BCD digits. Define FREQ_METER_BLANK_EN for leading-zero blanking.
module freq_meter_bcd #(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned GATE_MS     = 1000,
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signal,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  valid,
  output logic                  overflow,
  output logic                  busy
);

  function automatic int unsigned dec_digits(int unsigned w);
    longint unsigned v;
    int unsigned     n;
    v = (64'd1 << w) - 64'd1;
    n = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      n = n + 1;
    end
    return n;
  endfunction

  function automatic longint unsigned pow10(int unsigned d);
    longint unsigned p;
    p = 64'd1;
    for (int unsigned i = 0; i < d; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam int unsigned     GATE_CYCLES = (CLK_HZ / 1000) * GATE_MS;
  localparam int unsigned     GATE_W      = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int unsigned     CNT_DIGITS  = dec_digits(CNT_W);
  localparam int unsigned     ACC_DIGITS  = (CNT_DIGITS > DIGITS) ? CNT_DIGITS : DIGITS;
  localparam int unsigned     ACC_W       = 4 * ACC_DIGITS;
  localparam int unsigned     ITER_W      = $clog2(CNT_W + 1);
  localparam int unsigned     DIG_W       = 4 * DIGITS;
  localparam longint unsigned OVF_LIMIT   = pow10(DIGITS);
  localparam logic [CNT_W-1:0] EDGE_MAX   = {CNT_W{1'b1}};

  // Parameter legality, reported at elaboration
  if (GATE_CYCLES <= CNT_W + 2) begin : g_bad_gate
    $error("freq_meter_bcd: GATE_CYCLES (%0d) must exceed CNT_W+2 (%0d)", GATE_CYCLES, CNT_W + 2);
  end
  if (DIGITS < 1 || DIGITS > 9) begin : g_bad_digits
    $error("freq_meter_bcd: DIGITS (%0d) must be 1..9", DIGITS);
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("freq_meter_bcd: SYNC_STAGES (%0d) must be >= 2", SYNC_STAGES);
  end
  if (CNT_W < 2 || CNT_W > 63) begin : g_bad_cnt
    $error("freq_meter_bcd: CNT_W (%0d) must be 2..63", CNT_W);
  end

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   rise;
  logic [GATE_W-1:0]      gate_cnt;
  logic                   gate_end;
  logic [CNT_W-1:0]       edge_cnt;
  logic                   edge_inc;
  logic [CNT_W-1:0]       snap_c;
  logic [CNT_W-1:0]       snap_q;
  logic                   ovf_cmp_q;
  logic [ITER_W-1:0]      iter_q;
  logic [ACC_W-1:0]       acc_q;
  logic [ACC_W-1:0]       acc_adj;
  logic [ACC_W-1:0]       acc_nxt;
  logic [DIG_W-1:0]       digits_c;

  // Synchroniser and rising-edge history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], signal};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

  // Free-running gate timer
  assign gate_end = (gate_cnt == GATE_W'(GATE_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           gate_cnt <= '0;
    else if (gate_end) gate_cnt <= '0;
    else               gate_cnt <= gate_cnt + GATE_W'(1);
  end

  // Saturating edge counter; a rise in the gate-end cycle still belongs to the closing window
  assign edge_inc = rise && (edge_cnt != EDGE_MAX);
  assign snap_c   = edge_inc ? (edge_cnt + CNT_W'(1)) : edge_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           edge_cnt <= '0;
    else if (gate_end) edge_cnt <= '0;
    else if (edge_inc) edge_cnt <= edge_cnt + CNT_W'(1);
  end

  // One double-dabble step: add 3 to nibbles >= 5, then shift in the next snapshot bit
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < int'(ACC_DIGITS); i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    acc_nxt = {acc_adj[ACC_W-2:0], snap_q[CNT_W-1]};
  end

`ifdef FREQ_METER_BLANK_EN
  logic lead;

  // Result formatting with leading nibbles above the top non-zero digit forced to blank
  always_comb begin
    lead     = 1'b1;
    digits_c = acc_q[DIG_W-1:0];
    if (ovf_cmp_q) begin
      digits_c = {DIGITS{4'h9}};
    end else begin
      for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
        if (lead && (digits_c[4*i +: 4] == 4'h0)) digits_c[4*i +: 4] = 4'hF;
        else                                        lead = 1'b0;
      end
    end
  end
`else
  // Result formatting: saturate to all nines on overflow
  always_comb begin
    digits_c = acc_q[DIG_W-1:0];
    if (ovf_cmp_q) digits_c = {DIGITS{4'h9}};
  end
`endif

  // Conversion sequencer with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      snap_q    <= '0;
      ovf_cmp_q <= 1'b0;
      iter_q    <= '0;
      acc_q     <= '0;
      digits    <= '0;
      valid     <= 1'b0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (gate_end) begin
            snap_q    <= snap_c;
            ovf_cmp_q <= (64'(snap_c) >= OVF_LIMIT);
            acc_q     <= '0;
            iter_q    <= ITER_W'(CNT_W);
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          acc_q  <= acc_nxt;
          snap_q <= {snap_q[CNT_W-2:0], 1'b0};
          iter_q <= iter_q - ITER_W'(1);
          if (iter_q == ITER_W'(1)) state <= DONE;
        end
        DONE: begin
          digits   <= digits_c;
          overflow <= ovf_cmp_q;
          valid    <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter_bcd.sv
// Scoreboard bench for freq_meter_bcd: a 4-digit and a 1-digit instance share one stimulus;
// expected results come from an edge-history model of each gate window.
module tb_freq_meter_bcd;

  localparam int unsigned CLK_HZ  = 100000;
  localparam int unsigned GATE_MS = 1;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned SS      = 2;
  localparam int          GC      = 100;
  localparam int          LAT     = CNT_W + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signal = 1'b0;
  logic [15:0] digits4;
  logic        valid4, ovf4, busy4;
  logic [3:0]  digits1;
  logic        valid1, ovf1, busy1;

  freq_meter_bcd #(.CLK_HZ(CLK_HZ), .GATE_MS(GATE_MS), .DIGITS(4), .CNT_W(CNT_W), .SYNC_STAGES(SS)) u_dut4 (
    .clk(clk), .rst(rst), .signal(signal),
    .digits(digits4), .valid(valid4), .overflow(ovf4), .busy(busy4));

  freq_meter_bcd #(.CLK_HZ(CLK_HZ), .GATE_MS(GATE_MS), .DIGITS(1), .CNT_W(CNT_W), .SYNC_STAGES(SS)) u_dut1 (
    .clk(clk), .rst(rst), .signal(signal),
    .digits(digits1), .valid(valid1), .overflow(ovf1), .busy(busy1));

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] d4;
    logic        o4;
    logic [3:0]  d1;
    logic        o1;
  } exp_t;

  exp_t        sb[$];
  bit          shist[$];
  int          ecnt = 0;
  int          checks = 0;
  int          errors = 0;
  int          nvalid = 0;
  logic [15:0] held4 = '0;
  logic        held_o4 = 1'b0;
  logic [3:0]  held1 = '0;
  logic        held_o1 = 1'b0;

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecnt - 1);
    end
  endtask

  // Decimal rendering of a window count, nines on overflow, optional blanking
  function automatic logic [35:0] exp_digits(int cnt, int nd);
    logic [35:0] r;
    int          v;
    r = '0;
    v = cnt;
    if (cnt >= 10 ** nd) begin
      for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'h9;
      return r;
    end
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
`ifdef FREQ_METER_BLANK_EN
    for (int i = nd - 1; i >= 1; i--) begin
      if (r[4*i +: 4] != 4'h0) break;
      r[4*i +: 4] = 4'hF;
    end
`endif
    return r;
  endfunction

  // Record the sampled input per edge; at each gate close, count rises that reach the counter
  // inside this window (sample at edge j is seen by the counter at edge j+SS).
  always @(posedge clk) begin
    int          cnt;
    int          j;
    logic [35:0] r;
    exp_t        x;
    if (rst) begin
      ecnt = 0;
      shist.delete();
    end else begin
      shist.push_back(signal);
      if (ecnt % GC == GC - 1) begin
        cnt = 0;
        for (int d = ecnt - GC + 1; d <= ecnt; d++) begin
          j = d - int'(SS);
          if (j >= 0) begin
            if (shist[j] && (j == 0 || !shist[j-1])) cnt++;
          end
        end
        x.due = ecnt + LAT;
        r = exp_digits(cnt, 4);
        x.d4 = r[15:0];
        x.o4 = (cnt >= 10000);
        r = exp_digits(cnt, 1);
        x.d1 = r[3:0];
        x.o1 = (cnt >= 10);
        sb.push_back(x);
      end
      ecnt++;
    end
  end

  // Monitor: compare outputs against the scoreboard between clock edges
  initial begin
    int   last;
    bit   due_now;
    bit   exp_busy;
    exp_t x;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        sb.delete();
        held4 = '0; held_o4 = 1'b0; held1 = '0; held_o1 = 1'b0;
        check("rst_valid", {valid4, valid1}, 0);
        check("rst_busy", {busy4, busy1}, 0);
        check("rst_digits4", digits4, 0);
        check("rst_ovf", {ovf4, ovf1}, 0);
      end else begin
        last = ecnt - 1;
        while (sb.size() > 0 && sb[0].due < last) begin
          checks++;
          errors++;
          $display("FAIL valid_timeout: no valid by edge %0d, required at edge %0d", last, sb[0].due);
          void'(sb.pop_front());
        end
        due_now  = (sb.size() > 0) && (sb[0].due == last);
        exp_busy = (sb.size() > 0) && (last >= sb[0].due - LAT) && (last <= sb[0].due - 1);
        check("valid4", valid4, due_now);
        check("valid1", valid1, due_now);
        check("busy4", busy4, exp_busy);
        check("busy1", busy1, exp_busy);
        if (due_now) begin
          x = sb.pop_front();
          held4 = x.d4; held_o4 = x.o4; held1 = x.d1; held_o1 = x.o1;
          nvalid++;
        end
        check("digits4", digits4, held4);
        check("ovf4", ovf4, held_o4);
        check("digits1", digits1, held1);
        check("ovf1", ovf1, held_o1);
      end
    end
  end

  task automatic do_reset(bit lvl, int n);
    @(negedge clk);
    rst = 1'b1;
    signal = lvl;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic hold(bit lvl, int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      signal = lvl;
    end
  endtask

  task automatic toggle_phase(int half, int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i % half == 0) signal = ~signal;
    end
  endtask

  task automatic random_phase(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      signal = 1'($urandom_range(0, 1));
    end
  endtask

  // One-cycle pulse whose rise reaches the counter off cycles after the gate-end edge
  task automatic pulse_at(int off);
    int k;
    int tgt;
    k = 0;
    tgt = (GC - 1 - int'(SS) + off) % GC;
    while ((ecnt % GC) != tgt && k < 2 * GC) begin
      @(negedge clk);
      k++;
    end
    signal = 1'b1;
    @(negedge clk);
    signal = 1'b0;
  endtask

  initial begin
    int k;
    do_reset(1'b0, 4);
    toggle_phase(5, 5 * GC);
    hold(1'b0, GC);
    pulse_at(0);
    hold(1'b0, 2 * GC);
    pulse_at(1);
    hold(1'b0, 2 * GC);
    toggle_phase(1, 3 * GC);

    // Abort a conversion with reset while 10 rises/gate continue
    k = 0;
    while (!busy4 && k < 3 * GC) begin
      @(negedge clk);
      k++;
    end
    if (!busy4) begin
      checks++;
      errors++;
      $display("FAIL busy_wait: busy=%0d after %0d cycles, required 1", busy4, k);
    end
    repeat (4) @(negedge clk);
    rst = 1'b1;
    toggle_phase(5, 3);
    rst = 1'b0;
    toggle_phase(5, 4 * GC);

    hold(1'b0, 3 * GC);
    do_reset(1'b1, 3);
    hold(1'b1, 3 * GC);

    repeat (8) toggle_phase(int'($urandom_range(1, 25)), int'($urandom_range(GC, 3 * GC)));
    random_phase(4 * GC);
    hold(1'b0, GC + LAT + 5);

    check("valid_count_ok", (nvalid >= 30), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
